// File: rtl/amm_read_responder.sv
// AMM read-only operand memory with programmable wait states, OKAY/SLVERR responses and
// saturating completion counters. Define AMM_LFSR_WAIT_EN to add LFSR-jittered wait states.
//   state | meaning
//   IDLE  | waitrequest high, sampling amm_read for a new request
//   WAIT  | request latched, counting down wait states
//   DONE  | completion cycle: waitrequest low, readdata/response valid
module amm_read_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int MEM_SIZE    = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              amm_read,
   input  logic [ADDR_W-1:0] amm_address,
   output logic [DATA_W-1:0] amm_readdata,
   output logic              amm_waitrequest,
   output logic [1:0]        amm_response,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic [15:0]       rd_count,
   output logic [15:0]       err_count
);

   localparam int MW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [4:0]          cnt_q, cnt_d;
   logic                wreq_q, wreq_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;
   logic [15:0]         rd_cnt_q, rd_cnt_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [4:0]          eff_wait;
   logic                rd_in_range;
   logic                wr_in_range;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   mem [MEM_SIZE];

`ifdef AMM_LFSR_WAIT_EN
   logic [7:0]          lfsr_q, lfsr_d;
   assign eff_wait = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
   assign eff_wait = 5'(WAIT_CYCLES);
`endif

   assign rd_in_range = ({{(32-ADDR_W){1'b0}}, addr_q} < 32'(MEM_SIZE));
   assign wr_in_range = ({{(32-ADDR_W){1'b0}}, cfg_addr} < 32'(MEM_SIZE));
   assign rd_word     = mem[addr_q[MW-1:0]];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wreq_d    = wreq_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      rd_cnt_d  = rd_cnt_q;
      err_cnt_d = err_cnt_q;
`ifdef AMM_LFSR_WAIT_EN
      lfsr_d    = lfsr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (amm_read) begin
               addr_d  = amm_address;
               cnt_d   = eff_wait;
               state_d = S_WAIT;
`ifdef AMM_LFSR_WAIT_EN
               lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            end
         end
         S_WAIT: begin
            // A dropped request is an abort, even on what would have been the completion edge
            if (!amm_read) begin
               state_d = S_IDLE;
            end else if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               wreq_d   = 1'b0;
               rdata_d  = rd_in_range ? rd_word : '0;
               resp_d   = rd_in_range ? 2'b00 : 2'b10;
               rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
               if (!rd_in_range && err_cnt_q != 16'hFFFF) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            wreq_d  = 1'b1;
            resp_d  = 2'b00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         wreq_q    <= 1'b1;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         rd_cnt_q  <= '0;
         err_cnt_q <= '0;
`ifdef AMM_LFSR_WAIT_EN
         lfsr_q    <= 8'hA5;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wreq_q    <= wreq_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         rd_cnt_q  <= rd_cnt_d;
         err_cnt_q <= err_cnt_d;
`ifdef AMM_LFSR_WAIT_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   // Preload port survives reset; a same-edge completion reads the pre-write contents
   always_ff @(posedge clk) begin
      if (cfg_we && wr_in_range) begin
         mem[cfg_addr[MW-1:0]] <= cfg_wdata;
      end
   end

   assign amm_readdata    = rdata_q;
   assign amm_waitrequest = wreq_q;
   assign amm_response    = resp_q;
   assign rd_count        = rd_cnt_q;
   assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_amm_read_responder.sv
// Self-checking bench for amm_read_responder: vector table plus scoreboard of expected
// completions, with hand-written abort, same-edge preload, mid-read reset and LFSR sequences.
module tb_amm_read_responder;

`ifdef AMM_LFSR_WAIT_EN
   localparam int WC = 1;
`else
   localparam int WC = 2;
`endif
   localparam int MS = 128;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        amm_read = 1'b0;
   logic [7:0]  amm_address = 8'h00;
   logic [7:0]  amm_readdata;
   logic        amm_waitrequest;
   logic [1:0]  amm_response;
   logic        cfg_we = 1'b0;
   logic [7:0]  cfg_addr = 8'h00;
   logic [7:0]  cfg_wdata = 8'h00;
   logic [15:0] rd_count;
   logic [15:0] err_count;

   amm_read_responder #(
      .ADDR_W(8), .DATA_W(8), .MEM_SIZE(MS), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .rst(rst), .amm_read(amm_read), .amm_address(amm_address),
      .amm_readdata(amm_readdata), .amm_waitrequest(amm_waitrequest),
      .amm_response(amm_response), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .rd_count(rd_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pre_we;
      logic [7:0] pre_a;
      logic [7:0] pre_d;
      logic [7:0] rd_a;
      logic [7:0] exp_d;
      logic [1:0] exp_r;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] resp;
      int         lat;
   } exp_t;

   exp_t        sb[$];
   int          nvec = 0;
   int          nerr = 0;
   int          exp_rd = 0;
   int          exp_err = 0;
   logic [7:0]  lfsr_m = 8'hA5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int cur_w();
`ifdef AMM_LFSR_WAIT_EN
      return WC + int'(lfsr_m[1:0]);
`else
      return WC;
`endif
   endfunction

   task automatic accept_model();
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] ed, input logic [1:0] er,
                          input bit cfg_on_done, input logic [7:0] cd, output int lat);
      exp_t e;
      exp_t got;
      e.data = ed; e.resp = er; e.lat = cur_w() + 1;
      sb.push_back(e);
      accept_model();
      @(negedge clk);
      amm_read = 1'b1; amm_address = a;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         cfg_we = 1'b0;
         if (!amm_waitrequest) begin
            lat = k;
            break;
         end
         if (k == 1) amm_address = ~a;
         if (cfg_on_done && k == e.lat - 1) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_wdata = cd;
         end
      end
      got = sb.pop_front();
      amm_read = 1'b0;
      check("latency", lat, got.lat);
      if (lat > 0) begin
         check("readdata", amm_readdata, got.data);
         check("response", amm_response, got.resp);
         exp_rd++;
         if (got.resp == 2'b10) exp_err++;
         @(posedge clk); #1;
         check("pulse_width", amm_waitrequest, 1'b1);
         check("readdata_hold", amm_readdata, got.data);
         check("response_clear", amm_response, 2'b00);
         check("rd_count", rd_count, exp_rd);
         check("err_count", err_count, exp_err);
      end
   endtask

   task automatic do_abort();
      bit saw;
      accept_model();
      @(negedge clk);
      amm_read = 1'b1; amm_address = 8'h10;
      @(posedge clk);
      @(posedge clk); #1;
      amm_read = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (!amm_waitrequest) saw = 1'b1;
      end
      check("abort_no_pulse", saw, 1'b0);
      check("abort_rd_count", rd_count, exp_rd);
      check("abort_err_count", err_count, exp_err);
   endtask

   vec_t tbl[8];
   int   lat;
   int   wseq[20];

   initial begin
      tbl[0] = '{1'b1, 8'h10, 8'h3C, 8'h10, 8'h3C, 2'b00};
      tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h90, 8'h00, 2'b10};
      tbl[2] = '{1'b1, 8'h7F, 8'hA1, 8'h7F, 8'hA1, 2'b00};
      tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h80, 8'h00, 2'b10};
      tbl[4] = '{1'b1, 8'h00, 8'h5A, 8'h00, 8'h5A, 2'b00};
      tbl[5] = '{1'b1, 8'h80, 8'h77, 8'h80, 8'h00, 2'b10};
      tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h5A, 2'b00};
      tbl[7] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 2'b10};

      repeat (3) @(posedge clk);
      #1;
      check("rst_waitrequest", amm_waitrequest, 1'b1);
      check("rst_readdata", amm_readdata, 8'h00);
      check("rst_response", amm_response, 2'b00);
      check("rst_rd_count", rd_count, 16'd0);
      check("rst_err_count", err_count, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].pre_we) cfg_write(tbl[i].pre_a, tbl[i].pre_d);
         do_read(tbl[i].rd_a, tbl[i].exp_d, tbl[i].exp_r, 1'b0, 8'h00, lat);
      end

      do_abort();
      do_read(8'h10, 8'h3C, 2'b00, 1'b0, 8'h00, lat);

      do_read(8'h10, 8'h3C, 2'b00, 1'b1, 8'h55, lat);
      do_read(8'h10, 8'h55, 2'b00, 1'b0, 8'h00, lat);

      // reset asserted while the request sits in WAIT
      accept_model();
      @(negedge clk);
      amm_read = 1'b1; amm_address = 8'h10;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      amm_read = 1'b0;
      check("midrst_waitrequest", amm_waitrequest, 1'b1);
      check("midrst_rd_count", rd_count, 16'd0);
      check("midrst_err_count", err_count, 16'd0);
      check("midrst_response", amm_response, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      exp_rd = 0; exp_err = 0; lfsr_m = 8'hA5;
      repeat (4) begin
         @(posedge clk); #1;
         check("midrst_no_pulse", amm_waitrequest, 1'b1);
      end
      do_read(8'h10, 8'h55, 2'b00, 1'b0, 8'h00, lat);

`ifdef AMM_LFSR_WAIT_EN
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_rd = 0; exp_err = 0; lfsr_m = 8'hA5;
      for (int i = 0; i < 20; i++) begin
         do_read(8'h10, 8'h55, 2'b00, 1'b0, 8'h00, lat);
         wseq[i] = lat - 1;
         check("lfsr_w_range", (wseq[i] >= 1 && wseq[i] <= 4), 1'b1);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_rd = 0; exp_err = 0; lfsr_m = 8'hA5;
      for (int i = 0; i < 20; i++) begin
         do_read(8'h10, 8'h55, 2'b00, 1'b0, 8'h00, lat);
         check("lfsr_repeat", lat - 1, wseq[i]);
      end
`else
      wseq[0] = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
